// File: rtl/sap_exec_core.sv
// SAP-1 execution core: six-state ring controller, microcode decode, accumulator A,
// B register and the 8-bit adder/subtractor that feeds the W bus.
module sap_exec_core #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       instruction,
    input  logic [WIDTH-1:0] w_bus,
    output logic [11:0]      control_word,
    output logic [WIDTH-1:0] drive_data,
    output logic             drive_en,
    output logic [WIDTH-1:0] a_value,
    output logic             halted,
    output logic [5:0]       state_dbg
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Word layout {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}; loads are active low.
    localparam logic [11:0] CW_PC_TO_MAR  = 12'h5E3;
    localparam logic [11:0] CW_PC_INC     = 12'hBE3;
    localparam logic [11:0] CW_RAM_TO_IR  = 12'h263;
    localparam logic [11:0] CW_IR_TO_MAR  = 12'h1A3;
    localparam logic [11:0] CW_RAM_TO_A   = 12'h2C3;
    localparam logic [11:0] CW_RAM_TO_B   = 12'h2E1;
    localparam logic [11:0] CW_ALU_ADD    = 12'h3C7;
    localparam logic [11:0] CW_ALU_SUB    = 12'h3CF;
    localparam logic [11:0] CW_A_TO_OUT   = 12'h3F2;
    localparam logic [11:0] CW_IDLE       = 12'h3E3;

    localparam int BIT_LA_N = 5;
    localparam int BIT_EA   = 4;
    localparam int BIT_SU   = 3;
    localparam int BIT_EU   = 2;
    localparam int BIT_LB_N = 1;

    state_t           r_state;
    logic             r_halted;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [11:0]      w_cw;
    logic             w_hlt_now;
    logic             w_su;
    logic [WIDTH-1:0] w_alu;

    assign w_hlt_now = (r_state == T4) && (instruction == OP_HLT);

    // Fetch states ignore the opcode; once halted the word is pinned to idle.
    always_comb begin
        w_cw = CW_IDLE;
        if (!r_halted) begin
            case (r_state)
                T1: w_cw = CW_PC_TO_MAR;
                T2: w_cw = CW_PC_INC;
                T3: w_cw = CW_RAM_TO_IR;
                T4: begin
                    case (instruction)
                        OP_LDA, OP_ADD, OP_SUB: w_cw = CW_IR_TO_MAR;
                        OP_OUT:                 w_cw = CW_A_TO_OUT;
                        default:                w_cw = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (instruction)
                        OP_LDA:         w_cw = CW_RAM_TO_A;
                        OP_ADD, OP_SUB: w_cw = CW_RAM_TO_B;
                        default:        w_cw = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (instruction)
                        OP_ADD:  w_cw = CW_ALU_ADD;
                        OP_SUB:  w_cw = CW_ALU_SUB;
                        default: w_cw = CW_IDLE;
                    endcase
                end
                default: w_cw = CW_IDLE;
            endcase
        end
    end

    // Ring counter; HLT in T4 freezes the ring there until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= T1;
            r_halted <= 1'b0;
        end else if (r_halted || w_hlt_now) begin
            r_state  <= r_state;
            r_halted <= 1'b1;
        end else begin
            case (r_state)
                T1:      r_state <= T2;
                T2:      r_state <= T3;
                T3:      r_state <= T4;
                T4:      r_state <= T5;
                T5:      r_state <= T6;
                T6:      r_state <= T1;
                default: r_state <= T1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (!w_cw[BIT_LA_N]) r_a <= w_bus;
            if (!w_cw[BIT_LB_N]) r_b <= w_bus;
        end
    end

    // Subtract is two's complement: A + ~B + 1, wrapping mod 2^WIDTH.
    assign w_su  = w_cw[BIT_SU];
    assign w_alu = r_a + (w_su ? ~r_b : r_b) + {{(WIDTH-1){1'b0}}, w_su};

    assign control_word = w_cw;
    assign drive_data   = w_cw[BIT_EU] ? w_alu : r_a;
    assign drive_en     = w_cw[BIT_EA] | w_cw[BIT_EU];
    assign a_value      = r_a;
    assign halted       = r_halted;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_sap_exec_core.sv
// Directed bench for sap_exec_core: stimulus pushes the expected outputs of each
// cycle into a queue and a negedge monitor pops and compares them.
module tb_sap_exec_core;

    localparam int EW = 36;
    localparam logic [5:0] S1 = 6'h01;
    localparam logic [5:0] S2 = 6'h02;
    localparam logic [5:0] S3 = 6'h04;
    localparam logic [5:0] S4 = 6'h08;
    localparam logic [5:0] S5 = 6'h10;
    localparam logic [5:0] S6 = 6'h20;

    logic        clock;
    logic        reset;
    logic [3:0]  instruction;
    logic [7:0]  w_bus;
    logic [11:0] control_word;
    logic [7:0]  drive_data;
    logic        drive_en;
    logic [7:0]  a_value;
    logic        halted;
    logic [5:0]  state_dbg;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    sap_exec_core #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .w_bus        (w_bus),
        .control_word (control_word),
        .drive_data   (drive_data),
        .drive_en     (drive_en),
        .a_value      (a_value),
        .halted       (halted),
        .state_dbg    (state_dbg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string nm, input logic [11:0] cw, input logic [7:0] dd,
                        input logic de, input logic [7:0] a, input logic h,
                        input logic [5:0] st);
        exp_q.push_back({cw, dd, de, a, h, st});
        name_q.push_back(nm);
    endtask

    // Drive this cycle's inputs, queue the outputs expected in this state, advance.
    task automatic cyc(input string nm, input logic [3:0] ins, input logic [7:0] wb,
                       input logic [11:0] cw, input logic [7:0] dd, input logic de,
                       input logic [7:0] a, input logic h, input logic [5:0] st);
        instruction = ins;
        w_bus       = wb;
        push(nm, cw, dd, de, a, h, st);
        tick();
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] g;
            string         nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {control_word, drive_data, drive_en, a_value, halted, state_dbg};
            n_checks++;
            if (g === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got cw=%h dd=%h de=%b a=%h h=%b st=%b, expected cw=%h dd=%h de=%b a=%h h=%b st=%b",
                         nm, g[35:24], g[23:16], g[15], g[14:7], g[6], g[5:0],
                         e[35:24], e[23:16], e[15], e[14:7], e[6], e[5:0]);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        instruction = 4'h0;
        w_bus       = 8'h00;
        tick();
        cyc("reset_held", 4'h0, 8'h00, 12'h5E3, 8'h00, 1'b0, 8'h00, 1'b0, S1);
        reset = 1'b0;

        // LDA with a zero operand: full control word sequence
        cyc("lda0_t1", 4'h0, 8'h00, 12'h5E3, 8'h00, 1'b0, 8'h00, 1'b0, S1);
        cyc("lda0_t2", 4'h0, 8'h00, 12'hBE3, 8'h00, 1'b0, 8'h00, 1'b0, S2);
        cyc("lda0_t3", 4'h0, 8'h00, 12'h263, 8'h00, 1'b0, 8'h00, 1'b0, S3);
        cyc("lda0_t4", 4'h0, 8'h00, 12'h1A3, 8'h00, 1'b0, 8'h00, 1'b0, S4);
        cyc("lda0_t5", 4'h0, 8'h00, 12'h2C3, 8'h00, 1'b0, 8'h00, 1'b0, S5);
        cyc("lda0_t6", 4'h0, 8'h00, 12'h3E3, 8'h00, 1'b0, 8'h00, 1'b0, S6);

        // LDA 2Ah; opcode held at HLT through fetch must be ignored
        cyc("lda2a_t1", 4'hF, 8'h00, 12'h5E3, 8'h00, 1'b0, 8'h00, 1'b0, S1);
        cyc("lda2a_t2", 4'hF, 8'h00, 12'hBE3, 8'h00, 1'b0, 8'h00, 1'b0, S2);
        cyc("lda2a_t3", 4'hF, 8'h00, 12'h263, 8'h00, 1'b0, 8'h00, 1'b0, S3);
        cyc("lda2a_t4", 4'h0, 8'h00, 12'h1A3, 8'h00, 1'b0, 8'h00, 1'b0, S4);
        cyc("lda2a_t5", 4'h0, 8'h2A, 12'h2C3, 8'h00, 1'b0, 8'h00, 1'b0, S5);
        cyc("lda2a_t6", 4'h0, 8'hFF, 12'h3E3, 8'h2A, 1'b0, 8'h2A, 1'b0, S6);

        // ADD 10h: 2Ah + 10h = 3Ah
        cyc("add_t1", 4'h1, 8'h00, 12'h5E3, 8'h2A, 1'b0, 8'h2A, 1'b0, S1);
        cyc("add_t2", 4'h1, 8'h00, 12'hBE3, 8'h2A, 1'b0, 8'h2A, 1'b0, S2);
        cyc("add_t3", 4'h1, 8'h00, 12'h263, 8'h2A, 1'b0, 8'h2A, 1'b0, S3);
        cyc("add_t4", 4'h1, 8'h00, 12'h1A3, 8'h2A, 1'b0, 8'h2A, 1'b0, S4);
        cyc("add_t5", 4'h1, 8'h10, 12'h2E1, 8'h2A, 1'b0, 8'h2A, 1'b0, S5);
        cyc("add_t6", 4'h1, 8'h3A, 12'h3C7, 8'h3A, 1'b1, 8'h2A, 1'b0, S6);

        // LDA 05h
        cyc("lda05_t1", 4'h0, 8'h00, 12'h5E3, 8'h3A, 1'b0, 8'h3A, 1'b0, S1);
        cyc("lda05_t2", 4'h0, 8'h00, 12'hBE3, 8'h3A, 1'b0, 8'h3A, 1'b0, S2);
        cyc("lda05_t3", 4'h0, 8'h00, 12'h263, 8'h3A, 1'b0, 8'h3A, 1'b0, S3);
        cyc("lda05_t4", 4'h0, 8'h00, 12'h1A3, 8'h3A, 1'b0, 8'h3A, 1'b0, S4);
        cyc("lda05_t5", 4'h0, 8'h05, 12'h2C3, 8'h3A, 1'b0, 8'h3A, 1'b0, S5);
        cyc("lda05_t6", 4'h0, 8'h00, 12'h3E3, 8'h05, 1'b0, 8'h05, 1'b0, S6);

        // SUB 07h: 05h - 07h wraps to FEh
        cyc("sub_t1", 4'h2, 8'h00, 12'h5E3, 8'h05, 1'b0, 8'h05, 1'b0, S1);
        cyc("sub_t2", 4'h2, 8'h00, 12'hBE3, 8'h05, 1'b0, 8'h05, 1'b0, S2);
        cyc("sub_t3", 4'h2, 8'h00, 12'h263, 8'h05, 1'b0, 8'h05, 1'b0, S3);
        cyc("sub_t4", 4'h2, 8'h00, 12'h1A3, 8'h05, 1'b0, 8'h05, 1'b0, S4);
        cyc("sub_t5", 4'h2, 8'h07, 12'h2E1, 8'h05, 1'b0, 8'h05, 1'b0, S5);
        cyc("sub_t6", 4'h2, 8'hFE, 12'h3CF, 8'hFE, 1'b1, 8'h05, 1'b0, S6);

        // LDA 5Ch
        cyc("lda5c_t1", 4'h0, 8'h00, 12'h5E3, 8'hFE, 1'b0, 8'hFE, 1'b0, S1);
        cyc("lda5c_t2", 4'h0, 8'h00, 12'hBE3, 8'hFE, 1'b0, 8'hFE, 1'b0, S2);
        cyc("lda5c_t3", 4'h0, 8'h00, 12'h263, 8'hFE, 1'b0, 8'hFE, 1'b0, S3);
        cyc("lda5c_t4", 4'h0, 8'h00, 12'h1A3, 8'hFE, 1'b0, 8'hFE, 1'b0, S4);
        cyc("lda5c_t5", 4'h0, 8'h5C, 12'h2C3, 8'hFE, 1'b0, 8'hFE, 1'b0, S5);
        cyc("lda5c_t6", 4'h0, 8'h00, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S6);

        // OUT: A drives the bus in T4
        cyc("out_t1", 4'hE, 8'h00, 12'h5E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S1);
        cyc("out_t2", 4'hE, 8'h00, 12'hBE3, 8'h5C, 1'b0, 8'h5C, 1'b0, S2);
        cyc("out_t3", 4'hE, 8'h00, 12'h263, 8'h5C, 1'b0, 8'h5C, 1'b0, S3);
        cyc("out_t4", 4'hE, 8'h00, 12'h3F2, 8'h5C, 1'b1, 8'h5C, 1'b0, S4);
        cyc("out_t5", 4'hE, 8'h00, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S5);
        cyc("out_t6", 4'hE, 8'h00, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S6);

        // Undefined opcode behaves as NOP; bus noise must not load A
        cyc("nop_t1", 4'h5, 8'h00, 12'h5E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S1);
        cyc("nop_t2", 4'h5, 8'h00, 12'hBE3, 8'h5C, 1'b0, 8'h5C, 1'b0, S2);
        cyc("nop_t3", 4'h5, 8'h00, 12'h263, 8'h5C, 1'b0, 8'h5C, 1'b0, S3);
        cyc("nop_t4", 4'h5, 8'h99, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S4);
        cyc("nop_t5", 4'h5, 8'h99, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S5);
        cyc("nop_t6", 4'h5, 8'h99, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S6);

        // HLT: ring freezes in T4, word idle whatever the opcode becomes
        cyc("hlt_t1", 4'hF, 8'h00, 12'h5E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S1);
        cyc("hlt_t2", 4'hF, 8'h00, 12'hBE3, 8'h5C, 1'b0, 8'h5C, 1'b0, S2);
        cyc("hlt_t3", 4'hF, 8'h00, 12'h263, 8'h5C, 1'b0, 8'h5C, 1'b0, S3);
        cyc("hlt_t4", 4'hF, 8'h00, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b0, S4);
        cyc("hlt_frz1", 4'hF, 8'h33, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b1, S4);
        cyc("hlt_frz2", 4'h1, 8'h44, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b1, S4);
        cyc("hlt_frz3", 4'h0, 8'h55, 12'h3E3, 8'h5C, 1'b0, 8'h5C, 1'b1, S4);

        // Reset pulse between clock edges releases halt immediately
        reset = 1'b1;
        #2;
        reset = 1'b0;
        cyc("halt_arst", 4'h0, 8'h00, 12'h5E3, 8'h00, 1'b0, 8'h00, 1'b0, S1);
        cyc("lda77_t2", 4'h0, 8'h00, 12'hBE3, 8'h00, 1'b0, 8'h00, 1'b0, S2);
        cyc("lda77_t3", 4'h0, 8'h00, 12'h263, 8'h00, 1'b0, 8'h00, 1'b0, S3);
        cyc("lda77_t4", 4'h0, 8'h00, 12'h1A3, 8'h00, 1'b0, 8'h00, 1'b0, S4);
        cyc("lda77_t5", 4'h0, 8'h77, 12'h2C3, 8'h00, 1'b0, 8'h00, 1'b0, S5);
        cyc("lda77_t6", 4'h0, 8'h00, 12'h3E3, 8'h77, 1'b0, 8'h77, 1'b0, S6);

        // ADD aborted by a reset pulse in the middle of T5
        cyc("addab_t1", 4'h1, 8'h00, 12'h5E3, 8'h77, 1'b0, 8'h77, 1'b0, S1);
        cyc("addab_t2", 4'h1, 8'h00, 12'hBE3, 8'h77, 1'b0, 8'h77, 1'b0, S2);
        cyc("addab_t3", 4'h1, 8'h00, 12'h263, 8'h77, 1'b0, 8'h77, 1'b0, S3);
        cyc("addab_t4", 4'h1, 8'h00, 12'h1A3, 8'h77, 1'b0, 8'h77, 1'b0, S4);
        instruction = 4'h1;
        w_bus       = 8'h11;
        reset       = 1'b1;
        #2;
        reset       = 1'b0;
        cyc("addab_rst", 4'h1, 8'h11, 12'h5E3, 8'h00, 1'b0, 8'h00, 1'b0, S1);

        // Resume the ADD from a cleared A: 00h + 09h
        cyc("add9_t2", 4'h1, 8'h00, 12'hBE3, 8'h00, 1'b0, 8'h00, 1'b0, S2);
        cyc("add9_t3", 4'h1, 8'h00, 12'h263, 8'h00, 1'b0, 8'h00, 1'b0, S3);
        cyc("add9_t4", 4'h1, 8'h00, 12'h1A3, 8'h00, 1'b0, 8'h00, 1'b0, S4);
        cyc("add9_t5", 4'h1, 8'h09, 12'h2E1, 8'h00, 1'b0, 8'h00, 1'b0, S5);
        cyc("add9_t6", 4'h1, 8'h09, 12'h3C7, 8'h09, 1'b1, 8'h00, 1'b0, S6);
        cyc("add9_next", 4'h0, 8'h00, 12'h5E3, 8'h09, 1'b0, 8'h09, 1'b0, S1);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
